// File: rtl/life_pkg.sv
// Shared types and constants for the 8x8 life-grid display path.
//
// Contents:
//   GRID_W, ROWS, COLS : grid geometry
//   grid_t             : one full generation, row r in bits [8r+7:8r]
//   row_t              : one row of column bits (bit c = column c)
//   scan_state_t       : scan FSM states (IDLE, SCAN, BLANK)
//   grid_row()         : extracts one row of a generation
package life_pkg;

    localparam int unsigned GRID_W = 64;
    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;

    typedef logic [GRID_W-1:0] grid_t;
    typedef logic [COLS-1:0]   row_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        BLANK
    } scan_state_t;

    // Row r lives in byte r of the generation word.
    function automatic row_t grid_row(input grid_t g, input logic [2:0] r);
        return g[{r, 3'b000} +: COLS];
    endfunction

endpackage

// File: rtl/grid_scan_display_if.sv
// Valid/ready handshake carrying one 64-bit generation from the evolver.
//
// Signals:
//   grid_in    : generation word (row r = grid_in[8r+7:8r])
//   grid_valid : producer holds a new generation on grid_in
//   grid_ready : consumer can accept a generation this cycle
//
// Modports:
//   master : producer side (evolver / testbench)
//   slave  : consumer side (grid_scan_display)
interface grid_scan_display_if;
    import life_pkg::*;

    grid_t grid_in;
    logic  grid_valid;
    logic  grid_ready;

    modport master (
        output grid_in,
        output grid_valid,
        input  grid_ready
    );

    modport slave (
        input  grid_in,
        input  grid_valid,
        output grid_ready
    );

endinterface

// File: rtl/grid_frame_buffer.sv
// Double buffer for incoming generations.
//
// A transfer on the handshake lands in the shadow buffer. The scan FSM asks
// for a swap (swap_req) when it is idle or at a frame boundary; the swap only
// happens if the shadow holds a generation, which keeps a displayed frame
// intact from row 0 to row 7.
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous, active-low
//   gif         : generation handshake (slave side), drives grid_ready
//   swap_req    : FSM is at a point where a new frame may be taken
//   shadow_full : shadow buffer holds a not-yet-displayed generation
//   active      : generation currently being displayed
module grid_frame_buffer
    import life_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    grid_scan_display_if.slave  gif,
    input  logic                swap_req,
    output logic                shadow_full,
    output grid_t               active
);

    grid_t shadow_q;
    logic  grid_ready_q;
    logic  take;
    logic  swap;
    logic  shadow_full_d;

    assign take = gif.grid_valid && grid_ready_q;
    assign swap = swap_req && shadow_full;

    // take and swap are mutually exclusive: take needs an empty shadow,
    // swap needs a full one. A grid offered in the swap cycle is therefore
    // refused and accepted one cycle later.
    always_comb begin
        shadow_full_d = shadow_full;
        if (swap) begin
            shadow_full_d = 1'b0;
        end
        if (take) begin
            shadow_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow_q     <= '0;
            active       <= '0;
            shadow_full  <= 1'b0;
            grid_ready_q <= 1'b1;
        end else begin
            if (take) begin
                shadow_q <= gif.grid_in;
            end
            if (swap) begin
                active <= shadow_q;
            end
            shadow_full  <= shadow_full_d;
            // Registered from the next value so ready never lags a fill.
            grid_ready_q <= !shadow_full_d;
        end
    end

    assign gif.grid_ready = grid_ready_q;

endmodule

// File: rtl/grid_scan_display.sv
// Row-multiplexed LED matrix driver for the 8x8 life grid.
//
// Accepts generations over a valid/ready handshake into a double buffer and
// scans the active generation one row at a time, each row held for
// DWELL_CYCLES clocks. A newly received generation is only shown from the
// next frame boundary on. Once started, the scan repeats the active frame
// until reset.
//
// Optional build macro SCAN_BLANK_EN: inserts BLANK_CYCLES all-off clocks
// after every row (including row 7 -> row 0) for anti-ghosting. Without it
// rows switch back-to-back and BLANK_CYCLES is ignored.
//
// Ports:
//   clk        : system clock, rising edge
//   reset      : synchronous, active-low
//   gif        : generation handshake (slave side)
//   row_sel    : one-hot active row, zero when idle or blanking
//   col_data   : column bits of the active row, 1 = cell on
//   frame_done : one-cycle pulse when the row 7 dwell completes
//   busy       : scanning (any state but IDLE)
//
// All outputs are registered from the current FSM state, so the matrix pins
// follow the FSM by one clock; frame_done lines up with the last displayed
// cycle of row 7.
module grid_scan_display
    import life_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    grid_scan_display_if.slave  gif,
    output row_t                row_sel,
    output row_t                col_data,
    output logic                frame_done,
    output logic                busy
);

    localparam int unsigned RowW   = $clog2(ROWS);
    localparam int unsigned DwellW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [RowW-1:0]   RowLast   = RowW'(ROWS - 1);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYCLES - 1);

    // Parameter legality, checked at elaboration.
    if (DWELL_CYCLES < 2) begin : g_bad_dwell
        $error("DWELL_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES < 1) begin : g_bad_blank
        $error("BLANK_CYCLES must be at least 1");
    end

`ifdef SCAN_BLANK_EN
    localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);

    logic [BlankW-1:0] blank_cnt_q;
`endif

    scan_state_t       state_q;
    logic [RowW-1:0]   row_q;
    logic [DwellW-1:0] dwell_cnt_q;

    logic  shadow_full;
    grid_t active;
    logic  dwell_tc;
    logic  frame_end;
    logic  swap_req;

    assign dwell_tc  = (dwell_cnt_q == DwellLast);
    assign frame_end = (state_q == SCAN) && dwell_tc && (row_q == RowLast);
    // Frames may only change while idle or exactly at the row 7 terminal count.
    assign swap_req  = (state_q == IDLE) || frame_end;

    grid_frame_buffer u_frame_buffer (
        .clk         (clk),
        .reset       (reset),
        .gif         (gif),
        .swap_req    (swap_req),
        .shadow_full (shadow_full),
        .active      (active)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            dwell_cnt_q <= '0;
`ifdef SCAN_BLANK_EN
            blank_cnt_q <= '0;
`endif
            row_sel     <= '0;
            col_data    <= '0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy       <= (state_q != IDLE);
            frame_done <= frame_end;

            if (state_q == SCAN) begin
                row_sel  <= row_t'(1) << row_q;
                col_data <= grid_row(active, row_q);
            end else begin
                row_sel  <= '0;
                col_data <= '0;
            end

            unique case (state_q)
                IDLE: begin
                    // The frame buffer copies shadow to active in this same cycle.
                    if (shadow_full) begin
                        state_q     <= SCAN;
                        row_q       <= '0;
                        dwell_cnt_q <= '0;
                    end
                end

                SCAN: begin
                    if (dwell_tc) begin
                        dwell_cnt_q <= '0;
                        // Wraps 7 -> 0 naturally at the frame boundary.
                        row_q       <= row_q + 1'b1;
`ifdef SCAN_BLANK_EN
                        state_q     <= BLANK;
`endif
                    end else begin
                        dwell_cnt_q <= dwell_cnt_q + 1'b1;
                    end
                end

`ifdef SCAN_BLANK_EN
                BLANK: begin
                    if (blank_cnt_q == BlankLast) begin
                        blank_cnt_q <= '0;
                        state_q     <= SCAN;
                    end else begin
                        blank_cnt_q <= blank_cnt_q + 1'b1;
                    end
                end
`endif

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
